// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the byte-stream instruction memory loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        DONE = 3'd2,
        RUN  = 3'd3,
        ERR  = 3'd4
    } loader_state_t;

    localparam int          BYTE_W   = 8;
    localparam logic [7:0]  CKS_SEED = 8'h00;

endpackage

// File: rtl/imem_ram.sv
// Instruction RAM: synchronous write port, combinational read port, no reset.
module imem_ram #(
    parameter int n = 16,
    parameter int r = 3
) (
    input  logic         clk,
    input  logic         we,
    input  logic [r-1:0] waddr,
    input  logic [n-1:0] wdata,
    input  logic [r-1:0] raddr,
    output logic [n-1:0] rdata
);

    logic [n-1:0] mem [2**r];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/imem_loader.sv
// Loads a framed, XOR-checksummed byte stream into instruction RAM, then
// releases the CPU and serves RAM[pc] as the fetched instruction.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int n = 16,
    parameter int r = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_start,
    input  logic [r:0]   load_len,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic         cpu_run,
    input  logic [r-1:0] pc,
    output logic [n-1:0] instr
);

    localparam int             BYTES     = n / BYTE_W;
    localparam int             CW        = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [CW-1:0]  LAST_BYTE = CW'(BYTES - 1);

    loader_state_t  state;
    logic [r:0]     words_left;
    logic [r-1:0]   wr_addr;
    logic [CW-1:0]  byte_cnt;
    logic [n-1:0]   shift_reg;
    logic [7:0]     cks;

    logic           data_phase;
    logic           we;
    logic [n-1:0]   word_next;
    logic [n-1:0]   rdata;

    // Only bytes actually accepted in LOAD ever advance the frame.
    assign data_phase = (words_left != '0);
    assign word_next  = (shift_reg << BYTE_W) | n'(in_data);
    assign we         = (state == LOAD) && in_valid && data_phase && (byte_cnt == LAST_BYTE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            words_left <= '0;
            wr_addr    <= '0;
            byte_cnt   <= '0;
            shift_reg  <= '0;
            cks        <= CKS_SEED;
        end else begin
            case (state)
                IDLE, RUN, ERR: begin
                    if (load_start) begin
                        state      <= LOAD;
                        words_left <= load_len;
                        wr_addr    <= '0;
                        byte_cnt   <= '0;
                        cks        <= CKS_SEED;
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        if (data_phase) begin
                            cks       <= cks ^ in_data;
                            shift_reg <= word_next;
                            if (byte_cnt == LAST_BYTE) begin
                                wr_addr    <= wr_addr + 1'b1;
                                words_left <= words_left - 1'b1;
                                byte_cnt   <= '0;
                            end else begin
                                byte_cnt <= byte_cnt + 1'b1;
                            end
                        end else begin
                            state <= ((cks ^ in_data) == 8'h00) ? DONE : ERR;
                        end
                    end
                end
                DONE: begin
                    state <= RUN;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    imem_ram #(
        .n(n),
        .r(r)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (wr_addr),
        .wdata (word_next),
        .raddr (pc),
        .rdata (rdata)
    );

    // Control outputs depend on registered state only; instr is a NOP unless running.
    assign in_ready = (state == LOAD);
    assign busy     = (state == LOAD);
    assign done     = (state == DONE);
    assign err      = (state == ERR);
    assign cpu_run  = (state == RUN);
    assign instr    = cpu_run ? rdata : '0;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed frames plus randomized reloads
// compared against a word-level model of the instruction memory.
module tb_imem_loader;

    logic        clk;
    logic        rst_n;
    logic        load_start;
    logic [3:0]  load_len;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        busy;
    logic        done;
    logic        err;
    logic        cpu_run;
    logic [2:0]  pc;
    logic [15:0] instr;

    int total;
    int bad;

    logic [15:0] model_mem   [8];
    logic [15:0] frame_words [8];

    imem_loader #(
        .n(16),
        .r(3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .load_len   (load_len),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .cpu_run    (cpu_run),
        .pc         (pc),
        .instr      (instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic logic [7:0] frame_cks(input int len);
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < len; i++) begin
            x = x ^ frame_words[i][15:8] ^ frame_words[i][7:0];
        end
        return x;
    endfunction

    // Sends a frame; stop_after >= 0 returns after that many bytes were accepted.
    task automatic applyStimulus(input int len, input logic [7:0] cks_byte, input bit gaps, input int stop_after);
        logic [7:0] b;
        bit         sent;
        load_len   = 4'(len);
        load_start = 1'b1;
        in_valid   = 1'b1;
        in_data    = 8'hEE;
        tick();
        load_start = 1'b0;
        in_valid   = 1'b0;
        checkOutput("busy_after_start", {31'd0, busy}, 32'd1);
        checkOutput("run_drop_on_start", {31'd0, cpu_run}, 32'd0);
        checkOutput("err_clear_on_start", {31'd0, err}, 32'd0);
        for (int i = 0; i <= 2 * len; i++) begin
            if (stop_after >= 0 && i >= stop_after) return;
            if (i == 2 * len)    b = cks_byte;
            else if (i % 2 == 0) b = frame_words[i / 2][15:8];
            else                 b = frame_words[i / 2][7:0];
            if (gaps) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                tick();
            end
            in_valid = 1'b1;
            in_data  = b;
            sent     = 1'b0;
            for (int c = 0; c < 20 && !sent; c++) begin
                sent = in_ready;
                tick();
            end
            if (!sent) checkOutput("handshake_timeout", 32'd0, 32'd1);
            if (sent && i < 2 * len && i % 2 == 1) model_mem[(i / 2) % 8] = frame_words[i / 2];
        end
        in_valid = 1'b0;
    endtask

    task automatic check_ram(input string tag, input bit running);
        for (int p = 0; p < 8; p++) begin
            pc = 3'(p);
            #1;
            checkOutput(tag, {16'd0, instr}, running ? {16'd0, model_mem[p]} : 32'd0);
        end
        tick();
    endtask

    task automatic expect_success(input string tag);
        checkOutput({tag, "_done"}, {31'd0, done}, 32'd1);
        checkOutput({tag, "_run_early"}, {31'd0, cpu_run}, 32'd0);
        tick();
        checkOutput({tag, "_done_once"}, {31'd0, done}, 32'd0);
        checkOutput({tag, "_run"}, {31'd0, cpu_run}, 32'd1);
        check_ram({tag, "_instr"}, 1'b1);
    endtask

    initial begin
        int len;
        bit gaps;
        total      = 0;
        bad        = 0;
        rst_n      = 1'b1;
        load_start = 1'b0;
        load_len   = '0;
        in_data    = '0;
        in_valid   = 1'b0;
        pc         = '0;
        for (int i = 0; i < 8; i++) model_mem[i] = 16'h0000;

        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_done", {31'd0, done}, 32'd0);
        checkOutput("reset_err", {31'd0, err}, 32'd0);
        checkOutput("reset_run", {31'd0, cpu_run}, 32'd0);
        checkOutput("reset_instr", {16'd0, instr}, 32'd0);
        tick();
        #3 rst_n = 1'b1;
        tick();

        // Two-word frame from IDLE.
        frame_words[0] = 16'h1234;
        frame_words[1] = 16'hABCD;
        applyStimulus(2, 8'h40, 1'b0, -1);
        expect_success("two_word");
        pc = 3'd0; #1;
        checkOutput("pc0_1234", {16'd0, instr}, 32'h1234);
        pc = 3'd1; #1;
        checkOutput("pc1_abcd", {16'd0, instr}, 32'hABCD);
        tick();

        // Bytes offered in RUN must be dropped.
        in_valid = 1'b1;
        in_data  = 8'h55;
        for (int i = 0; i < 3; i++) begin
            checkOutput("ready_low_in_run", {31'd0, in_ready}, 32'd0);
            tick();
        end
        in_valid = 1'b0;
        checkOutput("still_run", {31'd0, cpu_run}, 32'd1);
        check_ram("run_unchanged", 1'b1);

        // Asynchronous reset in the middle of a cycle.
        #3 rst_n = 1'b0;
        #1;
        checkOutput("async_rst_run", {31'd0, cpu_run}, 32'd0);
        checkOutput("async_rst_instr", {16'd0, instr}, 32'd0);
        checkOutput("async_rst_ready", {31'd0, in_ready}, 32'd0);
        #2 rst_n = 1'b1;
        tick();

        // Bad checksum.
        applyStimulus(2, 8'h41, 1'b0, -1);
        checkOutput("bad_err", {31'd0, err}, 32'd1);
        checkOutput("bad_done", {31'd0, done}, 32'd0);
        tick();
        checkOutput("bad_err_level", {31'd0, err}, 32'd1);
        checkOutput("bad_no_run", {31'd0, cpu_run}, 32'd0);
        check_ram("err_nop", 1'b0);

        // Recovery from ERR with the same frame sent through valid gaps.
        applyStimulus(2, 8'h40, 1'b1, -1);
        expect_success("gaps");

        // Full-length frame exercises address wrap.
        for (int i = 0; i < 8; i++) frame_words[i] = 16'(i);
        applyStimulus(8, 8'h00, 1'b0, -1);
        expect_success("len8");

        // Empty frame: checksum byte only, RAM untouched.
        applyStimulus(0, 8'h00, 1'b0, -1);
        expect_success("len0");

        // Reset after three bytes of a frame leaves word 0 written.
        frame_words[0] = 16'($urandom);
        frame_words[1] = 16'($urandom);
        applyStimulus(2, frame_cks(2), 1'b0, 3);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("midload_rst_busy", {31'd0, busy}, 32'd0);
        #2 rst_n = 1'b1;
        tick();
        checkOutput("midload_idle_ready", {31'd0, in_ready}, 32'd0);

        // Randomized reloads from RUN.
        for (int it = 0; it < 6; it++) begin
            len  = $urandom_range(1, 8);
            gaps = 1'($urandom);
            for (int i = 0; i < 8; i++) frame_words[i] = 16'($urandom);
            applyStimulus(len, frame_cks(len), gaps, -1);
            expect_success("rand_reload");
        end

        // Randomized corrupted frame.
        len = $urandom_range(1, 8);
        for (int i = 0; i < 8; i++) frame_words[i] = 16'($urandom);
        applyStimulus(len, frame_cks(len) ^ 8'h80, 1'b1, -1);
        checkOutput("rand_bad_err", {31'd0, err}, 32'd1);
        tick();
        check_ram("rand_bad_nop", 1'b0);
        applyStimulus(len, frame_cks(len), 1'b0, -1);
        expect_success("rand_recover");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout observed=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
